// File: rtl/xform_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : xform_pkg
//  Purpose : Shared types for the transform bank RAM + auto-sequencer:
//            FSM state encoding, pass encoding and the host address
//            bit-reverse helper.
//  Rev     : 1.0  initial release
// ============================================================================
package xform_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PASS_PRE  = 2'd0,
    PASS_FFT  = 2'd1,
    PASS_POST = 2'd2
  } pass_e;

  // Bit 0 is kept, bits [n:1] are mirrored in place, everything above n
  // is cleared. n is at most 15, so a 16-iteration loop covers it.
  function automatic logic [31:0] bit_reverse(input logic [31:0] a,
                                               input logic [3:0]  n);
    logic [31:0] r;
    r    = '0;
    r[0] = a[0];
    for (int i = 1; i < 16; i++) begin
      if (i <= int'(n)) r[i] = a[int'(n) + 1 - i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xform_bank_ram_seq_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module  : bank_ram
//  Purpose : One interleaved bank: DW x 2^RW simple dual-port RAM,
//            registered read (1-cycle latency, old data on same-address
//            read/write collision).
//  Ports   : clk      clock
//            we_i     write enable
//            waddr_i  write row
//            wdata_i  write data
//            raddr_i  read row
//            rdata_o  read data, valid one cycle after raddr_i
//  Rev     : 1.0  initial release
// ============================================================================
module bank_ram #(
  parameter int DW = 32,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [RW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [RW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**RW];
  logic [DW-1:0] rdata_q;

  // No reset: this is a RAM macro; consumers gate the output themselves.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/xform_bank_ram_seq.sv
`default_nettype none
// ============================================================================
//  Module  : xform_bank_ram_seq
//  Purpose : NBANK interleaved bank RAMs shared by a host port and NLANE
//            transform-engine lanes, plus a sequencer that runs a single
//            manual pass or chains IMDCT-pre -> FFT -> IMDCT-post over
//            nch+1 channel blocks.
//  Ports   : host     din/we/addr/bit_rev/size_log2 -> dout (1-cycle read)
//            control  start/auto/func/mode/nch/abort -> progress/done/err
//            engine   eng_start/eng_func/eng_mode/eng_ch out,
//                     eng_done/eng_busy in,
//                     lane eng_we/eng_waddr/eng_raddr/eng_wdata -> eng_rdata
//  Rev     : 1.0  initial release
// ============================================================================
module xform_bank_ram_seq
  import xform_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int NBANK = 4,
  parameter int NLANE = 2,
  parameter int CH_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       din,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic                bit_rev,
  input  logic [3:0]          size_log2,
  input  logic                start,
  input  logic                auto,
  input  logic                func,
  input  logic                mode,
  input  logic [CH_W-1:0]     nch,
  input  logic                abort,
  output logic [DW-1:0]       dout,
  output logic                eng_start,
  output logic                eng_func,
  output logic                eng_mode,
  output logic [CH_W-1:0]     eng_ch,
  input  logic                eng_done,
  input  logic                eng_busy,
  input  logic [NLANE-1:0]    eng_we,
  input  logic [NLANE*AW-1:0] eng_waddr,
  input  logic [NLANE*AW-1:0] eng_raddr,
  input  logic [NLANE*DW-1:0] eng_wdata,
  output logic [NLANE*DW-1:0] eng_rdata,
  output logic                progress,
  output logic                done,
  output logic                err
);

  localparam int NB = $clog2(NBANK);
  localparam int RW = AW - NB;

  // ---------------- sequencer state ----------------
  state_e          state_q, state_d;
  pass_e           pass_q, pass_d;
  logic [CH_W-1:0] ch_q, ch_d, nch_q, nch_d;
  logic            auto_q, auto_d;
  logic [3:0]      size_q, size_d;
  logic            err_q, err_d;
  logic            eng_start_q;
  logic            w_start_acc;
  logic            w_progress;

  // ---------------- bank steering ----------------
  logic [AW-1:0]   w_haddr;
  logic [AW-1:0]   w_off;
  logic [AW-1:0]   w_lwa [NLANE];
  logic [AW-1:0]   w_lra [NLANE];
  logic            w_bank_we [NBANK];
  logic [RW-1:0]   w_bank_wa [NBANK];
  logic [DW-1:0]   w_bank_wd [NBANK];
  logic [RW-1:0]   w_bank_ra [NBANK];
  logic [DW-1:0]   w_bank_rd [NBANK];
  logic            w_conflict;

  // Read-mux selects travel with the RAM read so data and bank line up.
  logic [NB-1:0]   hbank_q;
  logic            host_ok_q;
  logic [NB-1:0]   lane_rbank_q [NLANE];
  logic            lane_ok_q;

  assign w_progress = (state_q != ST_IDLE);

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    ch_d        = ch_q;
    nch_d       = nch_q;
    auto_d      = auto_q;
    size_d      = size_q;
    w_start_acc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !eng_busy) begin
          w_start_acc = 1'b1;
          state_d     = ST_LAUNCH;
          auto_d      = auto;
          nch_d       = nch;
          size_d      = size_log2;
          ch_d        = '0;
          if (auto || !func) begin
            pass_d = (!auto && mode) ? PASS_POST : PASS_PRE;
          end else begin
            pass_d = PASS_FFT;
          end
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (eng_done) state_d = ST_NEXT;
      ST_NEXT: begin
        if (!auto_q) begin
          state_d = ST_FIN;
        end else begin
          unique case (pass_q)
            PASS_PRE: begin
              pass_d  = PASS_FFT;
              state_d = ST_LAUNCH;
            end
            PASS_FFT: begin
              pass_d  = PASS_POST;
              state_d = ST_LAUNCH;
            end
            default: begin
              if (ch_q < nch_q) begin
                ch_d    = ch_q + CH_W'(1);
                pass_d  = PASS_PRE;
                state_d = ST_LAUNCH;
              end else begin
                state_d = ST_FIN;
              end
            end
          endcase
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      ch_d    = '0;
    end
  end

  // Host bus errors only count while the lanes own the banks.
  assign err_d = w_start_acc ? 1'b0
               : (err_q | (w_progress && (we || w_conflict)));

  // ---------------- address formation ----------------
  assign w_haddr = bit_rev ? AW'(bit_reverse(32'(addr), size_log2)) : addr;
  assign w_off   = AW'(ch_q) << size_q;

  always_comb begin
    for (int l = 0; l < NLANE; l++) begin
      w_lwa[l] = eng_waddr[l*AW +: AW] + w_off;
      w_lra[l] = eng_raddr[l*AW +: AW] + w_off;
    end
  end

  // Each bank has one write and one read port. Lanes are scanned from
  // index 0 upward and the first to claim a bank gets it, so lower lanes
  // win both write conflicts and shared-bank reads.
  always_comb begin : bank_mux
    logic [NBANK-1:0] wclaim;
    logic [NBANK-1:0] rclaim;
    wclaim     = '0;
    rclaim     = '0;
    w_conflict = 1'b0;
    for (int b = 0; b < NBANK; b++) begin
      w_bank_we[b] = 1'b0;
      w_bank_wa[b] = w_haddr[AW-1:NB];
      w_bank_wd[b] = din;
      w_bank_ra[b] = w_haddr[AW-1:NB];
    end
    if (!w_progress) begin
      w_bank_we[w_haddr[NB-1:0]] = we;
    end else begin
      for (int l = 0; l < NLANE; l++) begin
        if (eng_we[l]) begin
          if (wclaim[w_lwa[l][NB-1:0]]) begin
            w_conflict = 1'b1;
          end else begin
            wclaim[w_lwa[l][NB-1:0]]    = 1'b1;
            w_bank_we[w_lwa[l][NB-1:0]] = 1'b1;
            w_bank_wa[w_lwa[l][NB-1:0]] = w_lwa[l][AW-1:NB];
            w_bank_wd[w_lwa[l][NB-1:0]] = eng_wdata[l*DW +: DW];
          end
        end
        if (!rclaim[w_lra[l][NB-1:0]]) begin
          rclaim[w_lra[l][NB-1:0]]    = 1'b1;
          w_bank_ra[w_lra[l][NB-1:0]] = w_lra[l][AW-1:NB];
        end
      end
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    bank_ram #(.DW(DW), .RW(RW)) u_bank (
      .clk     (clk),
      .we_i    (w_bank_we[b]),
      .waddr_i (w_bank_wa[b]),
      .wdata_i (w_bank_wd[b]),
      .raddr_i (w_bank_ra[b]),
      .rdata_o (w_bank_rd[b])
    );
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pass_q      <= PASS_PRE;
      ch_q        <= '0;
      nch_q       <= '0;
      auto_q      <= 1'b0;
      size_q      <= '0;
      err_q       <= 1'b0;
      eng_start_q <= 1'b0;
      hbank_q     <= '0;
      host_ok_q   <= 1'b0;
      lane_ok_q   <= 1'b0;
      for (int l = 0; l < NLANE; l++) lane_rbank_q[l] <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      ch_q        <= ch_d;
      nch_q       <= nch_d;
      auto_q      <= auto_d;
      size_q      <= size_d;
      err_q       <= err_d;
      eng_start_q <= (state_q == ST_LAUNCH) && !abort;
      hbank_q     <= w_haddr[NB-1:0];
      host_ok_q   <= !w_progress;
      lane_ok_q   <= w_progress;
      for (int l = 0; l < NLANE; l++) lane_rbank_q[l] <= w_lra[l][NB-1:0];
    end
  end

  // ---------------- outputs ----------------
  assign dout = host_ok_q ? w_bank_rd[hbank_q] : '0;

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    assign eng_rdata[l*DW +: DW] = lane_ok_q ? w_bank_rd[lane_rbank_q[l]] : '0;
  end

  assign eng_start = eng_start_q;
  assign eng_func  = (pass_q == PASS_FFT);
  assign eng_mode  = (pass_q == PASS_POST);
  assign eng_ch    = ch_q;
  assign progress  = w_progress;
  assign done      = (state_q == ST_FIN) && !abort;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_xform_bank_ram_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_xform_bank_ram_seq
//  Purpose : Self-checking bench for xform_bank_ram_seq: host read/write
//            table, manual and auto sequencing, bus/lane error handling,
//            abort, and randomized lane traffic against a memory model.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_xform_bank_ram_seq;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int NBANK = 4;
  localparam int NLANE = 2;
  localparam int CH_W  = 3;
  localparam int SZ    = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [DW-1:0]       din = '0;
  logic                we = 1'b0;
  logic [AW-1:0]       addr = '0;
  logic                bit_rev = 1'b0;
  logic [3:0]          size_log2 = 4'd5;
  logic                start = 1'b0;
  logic                auto = 1'b0;
  logic                func = 1'b0;
  logic                mode = 1'b0;
  logic [CH_W-1:0]     nch = '0;
  logic                abort = 1'b0;
  logic [DW-1:0]       dout;
  logic                eng_start, eng_func, eng_mode;
  logic [CH_W-1:0]     eng_ch;
  logic                eng_done = 1'b0;
  logic                eng_busy = 1'b0;
  logic [NLANE-1:0]    eng_we = '0;
  logic [NLANE*AW-1:0] eng_waddr = '0;
  logic [NLANE*AW-1:0] eng_raddr = '0;
  logic [NLANE*DW-1:0] eng_wdata = '0;
  logic [NLANE*DW-1:0] eng_rdata;
  logic                progress, done, err;

  always #5 clk = ~clk;

  xform_bank_ram_seq #(.DW(DW), .AW(AW), .NBANK(NBANK), .NLANE(NLANE), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .we(we), .addr(addr), .bit_rev(bit_rev),
    .size_log2(size_log2), .start(start), .auto(auto), .func(func), .mode(mode),
    .nch(nch), .abort(abort), .dout(dout), .eng_start(eng_start), .eng_func(eng_func),
    .eng_mode(eng_mode), .eng_ch(eng_ch), .eng_done(eng_done), .eng_busy(eng_busy),
    .eng_we(eng_we), .eng_waddr(eng_waddr), .eng_raddr(eng_raddr), .eng_wdata(eng_wdata),
    .eng_rdata(eng_rdata), .progress(progress), .done(done), .err(err)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem_m [1<<AW];
  bit err_m;

  typedef struct {
    logic [AW-1:0] a;
    logic          br;
    logic [DW-1:0] exp;
  } rd_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Field [s:1] read as a number, its bits emitted in the opposite order.
  function automatic int unsigned model_rev(input int unsigned a, input int unsigned s);
    int unsigned field, rev;
    field = (a >> 1) & ((1 << s) - 1);
    rev   = 0;
    for (int k = 0; k < int'(s); k++) rev = (rev << 1) | ((field >> k) & 1);
    return (rev << 1) | (a & 1);
  endfunction

  task automatic host_write(input int unsigned a, input bit br, input logic [DW-1:0] d);
    we = 1'b1; addr = AW'(a); bit_rev = br; din = d;
    tick();
    we = 1'b0;
    mem_m[br ? model_rev(a, SZ) : a] = d;
  endtask

  task automatic host_read(input string name, input int unsigned a, input bit br,
                           input logic [DW-1:0] exp);
    addr = AW'(a); bit_rev = br;
    tick();
    chk(name, dout, exp);
  endtask

  task automatic do_start(input bit a, input bit f, input bit m, input int nc);
    auto = a; func = f; mode = m; nch = CH_W'(nc); size_log2 = 4'(SZ);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_pass();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    for (int i = 0; i < 6 && !done; i++) tick();
    chk("pass_done", done, 1);
    tick();
  endtask

  // Random lane traffic for one cycle; returns the read data expected one
  // cycle later and updates the memory model with the surviving writes.
  task automatic drive_ops(input int chm, output logic [NLANE*DW-1:0] exp);
    int unsigned wa[NLANE], ra[NLANE];
    bit          w[NLANE];
    logic [DW-1:0] wd[NLANE];
    bit blocked;
    int j;
    for (int l = 0; l < NLANE; l++) begin
      w[l]  = 1'($urandom_range(0, 1));
      wa[l] = $urandom_range(0, 63);
      ra[l] = $urandom_range(0, 63);
      wd[l] = $urandom;
      eng_we[l] = w[l];
      eng_waddr[l*AW +: AW] = AW'(wa[l]);
      eng_raddr[l*AW +: AW] = AW'(ra[l]);
      eng_wdata[l*DW +: DW] = wd[l];
      wa[l] = (wa[l] + chm * (1 << SZ)) % (1 << AW);
      ra[l] = (ra[l] + chm * (1 << SZ)) % (1 << AW);
    end
    for (int l = 0; l < NLANE; l++) begin
      j = l;
      for (int k = l - 1; k >= 0; k--) if ((ra[k] % NBANK) == (ra[l] % NBANK)) j = k;
      exp[l*DW +: DW] = mem_m[ra[j]];
    end
    for (int l = 0; l < NLANE; l++) begin
      blocked = 1'b0;
      for (int k = 0; k < l; k++) if (w[k] && (wa[k] % NBANK) == (wa[l] % NBANK)) blocked = 1'b1;
      if (w[l]) begin
        if (blocked) err_m = 1'b1;
        else mem_m[wa[l]] = wd[l];
      end
    end
  endtask

  // Acts as the engine for an auto run: checks each launch against the
  // chain order, optionally drives lanes while "computing", then answers.
  task automatic auto_run(input int nchv, input bit ops, input int stop_after,
                          output int n_starts, output int n_done);
    int wcnt, cyc, chm, p;
    bit pend;
    logic [NLANE*DW-1:0] exp_rd;
    wcnt = -1; cyc = 0; chm = 0; pend = 1'b0; exp_rd = '0;
    n_starts = 0; n_done = 0;
    while (cyc < 600 && n_done == 0) begin
      tick();
      cyc++;
      if (pend) chk("lane_rdata", eng_rdata, exp_rd);
      pend = 1'b0; eng_we = '0; eng_done = 1'b0;
      if (done) n_done++;
      if (eng_start) begin
        chm = n_starts / 3;
        p   = n_starts % 3;
        chk("auto_func", eng_func, (p == 1) ? 1 : 0);
        if (p != 1) chk("auto_mode", eng_mode, (p == 2) ? 1 : 0);
        chk("auto_ch", eng_ch, chm);
        n_starts++;
        if (n_starts > 3 * (nchv + 1)) chk("auto_extra_start", n_starts, 3 * (nchv + 1));
        if (n_starts == stop_after) return;
        wcnt = $urandom_range(3, 8);
      end else if (wcnt > 0) begin
        if (ops) begin
          drive_ops(chm, exp_rd);
          pend = 1'b1;
        end
        wcnt--;
      end else if (wcnt == 0) begin
        eng_done = 1'b1;
        wcnt = -1;
      end
    end
    if (stop_after == 0) chk("auto_done_seen", n_done, 1);
  endtask

  initial begin
    rd_vec_t rv [9];
    int ns, nd, dcnt;

    rv[0] = '{10'd2,  1'b0, 32'd32};
    rv[1] = '{10'd32, 1'b0, 32'd2};
    rv[2] = '{10'd0,  1'b0, 32'd0};
    rv[3] = '{10'd1,  1'b0, 32'd1};
    rv[4] = '{10'd63, 1'b0, 32'd63};
    rv[5] = '{10'd3,  1'b0, 32'd33};
    rv[6] = '{10'd48, 1'b0, 32'd6};
    rv[7] = '{10'd4,  1'b0, 32'd16};
    rv[8] = '{10'd6,  1'b1, 32'd6};

    // ---- reset values ----
    tick(); tick();
    chk("rst_dout", dout, 0);
    chk("rst_eng_rdata", eng_rdata, 0);
    chk("rst_ctrl", {eng_start, eng_func, eng_mode, progress, done, err}, 0);
    chk("rst_eng_ch", eng_ch, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_progress", progress, 0);

    // ---- host bit-reversed fill and read table ----
    size_log2 = 4'(SZ);
    for (int i = 0; i < 64; i++) host_write(i, 1'b1, DW'(i));
    for (int i = 0; i < 9; i++) host_read($sformatf("host_rd[%0d]", i), rv[i].a, rv[i].br, rv[i].exp);

    // bits above size_log2 are cleared by the reverse
    host_write(10'h3C2, 1'b1, 32'h55);
    host_read("brev_upper_zero", 32, 1'b0, 32'h55);

    // ---- start blocked while engine busy ----
    eng_busy = 1'b1;
    do_start(1'b0, 1'b1, 1'b0, 0);
    eng_busy = 1'b0;
    chk("busy_blocks_start", progress, 0);

    // ---- manual FFT timing ----
    do_start(1'b0, 1'b1, 1'b0, 0);
    chk("man_prog_rise", progress, 1);
    chk("man_estart_c1", eng_start, 0);
    tick();
    chk("man_estart_c2", eng_start, 1);
    chk("man_efunc", eng_func, 1);
    tick();
    chk("man_estart_pulse", eng_start, 0);
    repeat (98) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("man_done_p1", done, 0);
    tick();
    chk("man_done_p2", done, 1);
    chk("man_prog_at_done", progress, 1);
    tick();
    chk("man_prog_fall", progress, 0);
    chk("man_done_gone", done, 0);

    // ---- known contents for the engine region ----
    for (int i = 0; i < 128; i++) host_write(i, 1'b0, $urandom);

    // ---- host write during progress ----
    do_start(1'b0, 1'b0, 1'b1, 0);
    tick();
    we = 1'b1; addr = 10'd7; bit_rev = 1'b0; din = 32'hDEAD;
    tick();
    we = 1'b0;
    chk("busy_host_rd_zero", dout, 0);
    chk("busy_host_we_err", err, 1);
    finish_pass();
    host_read("busy_we_dropped", 7, 1'b0, mem_m[7]);
    chk("err_sticky", err, 1);

    // ---- lane write conflict ----
    do_start(1'b0, 1'b0, 1'b0, 0);
    chk("err_cleared_on_start", err, 0);
    tick();
    eng_we = 2'b11;
    eng_waddr = {10'd5, 10'd5};
    eng_wdata = {32'hB, 32'hA};
    tick();
    eng_we = '0;
    chk("conflict_err", err, 1);
    finish_pass();
    mem_m[5] = 32'hA;
    host_read("conflict_lane0_wins", 5, 1'b0, 32'hA);

    // ---- randomized auto runs ----
    for (int r = 1; r <= 2; r++) begin
      err_m = 1'b0;
      do_start(1'b1, 1'b0, 1'b0, r);
      auto_run(r, 1'b1, 0, ns, nd);
      chk("auto_starts", ns, 3 * (r + 1));
      chk("auto_err", err, err_m);
      tick();
      chk("auto_prog_fall", progress, 0);
      dcnt = 0;
      for (int i = 0; i < 5; i++) begin
        if (done) dcnt++;
        tick();
      end
      chk("auto_single_done", dcnt, 0);
      eng_we = '0;
      for (int i = 0; i < 8; i++) begin
        int unsigned a;
        a = $urandom_range(0, 127);
        host_read("auto_mem", a, 1'b0, mem_m[a]);
      end
    end

    // ---- abort during FFT of channel 0 ----
    do_start(1'b1, 1'b0, 1'b0, 1);
    auto_run(1, 1'b0, 2, ns, nd);
    chk("abort_at_fft", eng_func, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", progress, 0);
    chk("abort_ch", eng_ch, 0);
    chk("abort_no_estart", eng_start, 0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || eng_start) dcnt++;
      tick();
    end
    chk("abort_quiet", dcnt, 0);
    do_start(1'b0, 1'b0, 1'b0, 0);
    tick();
    chk("restart_estart", eng_start, 1);
    finish_pass();
    chk("restart_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/xform_bank_ram_seq.md
# xform_bank_ram_seq

Parametrised successor to the four-bank transform RAM wrapper: NBANK interleaved bank RAMs shared between a host port and the transform-engine lanes, plus an auto-sequencer. The sequencer chains IMDCT-pre -> FFT -> IMDCT-post over CH channel blocks without host intervention. It sits between the bus-side register/DMA logic and the imdct / r4r8 FFT cores in the audio decode datapath.

## Interface
Parameters:
- DW, 32, data word width
- AW, 10, host word-address width; total capacity 2^AW words
- NBANK, 4, number of bank RAMs; power of two, >=2
- NLANE, 2, engine lanes; NLANE <= NBANK
- CH_W, 3, width of channel-count field

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- din  in  DW  host write data
- we  in  1  host write strobe
- addr  in  AW  host word address
- bit_rev  in  1  host address bit-reverse enable
- size_log2  in  4  log2 of point count, 4..AW-1
- start  in  1  one-cycle start pulse
- auto  in  1  1 = auto sequence, 0 = manual single pass
- func  in  1  manual pass: 0 IMDCT, 1 FFT
- mode  in  1  manual IMDCT mode (0 pre, 1 post)
- nch  in  CH_W  channel blocks minus one (auto only)
- abort  in  1  synchronous abort
- dout  out  DW  host read data, 1-cycle latency
- eng_start  out  1  start pulse to selected engine
- eng_func  out  1  selected engine
- eng_mode  out  1  IMDCT mode to engine
- eng_ch  out  CH_W  current channel block index
- eng_done  in  1  engine done pulse
- eng_busy  in  1  engine in progress
- eng_we  in  NLANE  lane write strobes
- eng_waddr / eng_raddr  in  NLANE*AW  lane addresses, flattened
- eng_wdata  in  NLANE*DW  lane write data
- eng_rdata  out  NLANE*DW  lane read data, 1-cycle latency
- progress  out  1  block busy
- done  out  1  one-cycle completion pulse
- err  out  1  sticky; host access or lane conflict during progress

## Operation
- Banking: bank = addr[log2(NBANK)-1:0], row = addr >> log2(NBANK), with channel offset eng_ch << size_log2 added to engine addresses.
- Bit reverse (host only): bit 0 kept; bits [size_log2:1] reversed in place; bits above size_log2 forced 0.
- Host owns the banks when progress=0; engine lanes own them when progress=1.
- Host we during progress: write dropped, err set. Host reads during progress return 0.
- Lane conflict: two lanes writing the same bank in one cycle -> lower lane index wins, err set. Reads to the same bank return identical data and are not an error.
- err clears only on a new accepted start.
- FSM states: IDLE, LAUNCH, WAIT, NEXT, FIN.
  - IDLE: start accepted only when eng_busy=0, then -> LAUNCH. Pass latched: manual = (func, mode); auto = (IMDCT, pre); eng_ch=0.
  - LAUNCH: eng_start=1 for one cycle -> WAIT.
  - WAIT: on eng_done -> NEXT.
  - NEXT, manual: -> FIN.
  - NEXT, auto pass order: IMDCT-pre -> FFT -> IMDCT-post. After post, if eng_ch<nch then eng_ch+1 and pass resets to pre -> LAUNCH; otherwise -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- start while not IDLE is ignored.
- abort in any non-IDLE state -> IDLE next cycle; no done pulse; eng_ch=0.
- Inputs size_log2, auto, nch are sampled at start and held internally.

## Timing
- Reset values: dout=0, eng_rdata=0, eng_start=0, eng_func=0, eng_mode=0, eng_ch=0, progress=0, done=0, err=0, FSM=IDLE.
- progress rises the cycle after start is accepted and falls the cycle after done.
- Manual run: start -> eng_start 2 cycles later; eng_done -> done 2 cycles later.
- Bank-select for the read mux is registered alongside the RAM read, so dout matches the address of the previous cycle.
- eng_done arriving in LAUNCH is ignored. Engines must not assert done within one cycle of start.

## Structure
- Package xform_pkg: FSM state enum, pass encoding (PASS_PRE, PASS_FFT, PASS_POST), and the bit-reverse function.
- Sub-module bank_ram: one DW x 2^(AW-log2 NBANK) RAM with 1-cycle read, instantiated NBANK times via generate.

## Test plan
- Host write 0..63 at size_log2=5, bit_rev=1; read addr 2 with bit_rev=0 -> 32 (addr 2 reversed = 32); read latency is 1 cycle.
- Manual FFT: start, func=1 -> eng_start at cycle+2, eng_func=1; eng_done after 100 cycles -> done at +2, progress low the cycle after.
- Auto with nch=1 -> six eng_start pulses with (func,mode) = (0,0), (1,x), (0,1), repeated with eng_ch=1; one done pulse.
- Host we during progress -> RAM unchanged, err=1 until next start.
- Both lanes write bank 1 at once with 0xA, 0xB -> lane 0 value 0xA stored, err=1.
- abort during FFT pass of channel 0 -> IDLE next cycle, no done; a new start runs cleanly.
